// File: rtl/mmio_test_dev.sv
// Memory-mapped test responder: sticky pass/fail result, console byte FIFO,
// status readback and a free-running cycle counter that stops at completion.
module mmio_test_dev #(
  parameter logic [31:0] BASE       = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_code
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] OFF_TOHOST  = 2'd0;
  localparam logic [1:0] OFF_CONSOLE = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_CYCLE   = 2'd3;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic             r_overflow;
  logic [31:0]      r_cycle;
  logic             r_done;
  logic             r_pass;
  logic [30:0]      r_fail_code;
  logic [31:0]      r_rdata;

  logic [1:0]  w_offset;
  logic        w_wr;
  logic        w_result_wr;
  logic        w_push_req;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [31:0] w_status;
  logic [31:0] w_rdata_next;
  logic        w_unused_addr;

  assign w_offset      = addr[3:2];
  assign hit           = (addr[31:4] == BASE[31:4]);
  assign w_unused_addr = &{1'b0, addr[1:0]};

  assign w_wr        = hit && wr;
  assign w_result_wr = w_wr && (w_offset == OFF_TOHOST) && !r_done && (wdata != 32'd0);
  assign w_push_req  = w_wr && (w_offset == OFF_CONSOLE);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop       = (r_count != '0) && char_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = w_push_req && w_full && !w_pop;

  assign w_status = {22'b0, r_overflow, 7'(r_count), r_pass, r_done};

  always_comb begin
    w_rdata_next = 32'd0;
    if (hit) begin
      case (w_offset)
        OFF_STATUS: w_rdata_next = w_status;
        OFF_CYCLE:  w_rdata_next = r_cycle;
        default:    w_rdata_next = 32'd0;
      endcase
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata[7:0];
  end

  // Sticky test result, cycle counter and registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_code <= '0;
      r_cycle     <= 32'd0;
      r_rdata     <= 32'd0;
    end else begin
      if (w_result_wr) begin
        r_done      <= 1'b1;
        r_pass      <= (wdata == 32'd1);
        r_fail_code <= (wdata == 32'd1) ? 31'd0 : wdata[31:1];
      end
      if (!r_done) r_cycle <= r_cycle + 32'd1;
      r_rdata <= w_rdata_next;
    end
  end

  assign char_valid = (r_count != '0);
  assign char_data  = char_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail_code  = r_fail_code;
  assign rdata      = r_rdata;

endmodule

// File: doc/mmio_test_dev.md
# mmio_test_dev

Memory-mapped test responder on the CPU data port (addr/wdata/wr/data). The core stores a pass/fail result and console characters into it and reads back status and a cycle count. Benches then detect completion from the `done`/`pass` outputs instead of watching fixed instruction addresses. It sits beside dual_port_ram on the data bus; an external mux selects `rdata` when `hit` was high in the previous cycle.

## Interface
- BASE, 32'h0000_1000, word-aligned base of the 16-byte register window.
- FIFO_DEPTH, 8, console FIFO entries; power of two, minimum 2.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  32  CPU data address; addr[1:0] ignored.
- wdata  in  32  CPU store data.
- wr  in  1  store strobe, sampled at posedge.
- hit  out  1  combinational: addr[31:4] == BASE[31:4].
- rdata  out  32  registered read data, one cycle after addr.
- char_valid  out  1  console FIFO non-empty.
- char_data  out  8  FIFO head byte.
- char_ready  in  1  sink accepts head when char_valid && char_ready.
- done  out  1  sticky: a result was written.
- pass  out  1  sticky: the result was a pass.
- fail_code  out  31  failing test number, i.e. wdata[31:1] of the failing result.

## Operation
- Register map (offset = addr[3:2]):
  - 0 TOHOST: write-only, reads 0.
  - 1 CONSOLE: write-only, reads 0.
  - 2 STATUS: read-only, returns {22'b0, overflow, count[6:0], pass, done}.
  - 3 CYCLE: read-only, 32-bit cycle counter.
- Writes take effect only when hit && wr at the posedge. Writes to STATUS/CYCLE are ignored.
- TOHOST write of 0: ignored.
- TOHOST write of 1: done=1, pass=1, fail_code=0.
- TOHOST write of any other nonzero value: done=1, pass=0, fail_code=wdata[31:1].
- TOHOST writes after done=1 are ignored; the first result is sticky until reset.
- CONSOLE write pushes wdata[7:0]. If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and sticky overflow=1.
- Pop occurs on char_valid && char_ready.
- Push and pop in the same cycle: count unchanged. When full, the push is accepted because the pop frees the slot.
- FIFO uses a circular buffer. Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. count is log2(FIFO_DEPTH)+1 bits.
- CYCLE increments by 1 every clock while done=0. It wraps from 32'hFFFF_FFFF to 0. It freezes from the edge that sets done.
- rdata: at each posedge, rdata <= (hit && offset is STATUS or CYCLE) ? register value : 0.
  - Values read are the pre-edge values.
  - A read of CYCLE issued in cycle N returns the count from before edge N.

## Timing
- Reset values:
  - rdata=0, done=0, pass=0, fail_code=0.
  - char_valid=0, char_data=0, overflow=0, CYCLE=0, FIFO pointers/count=0.
  - hit is combinational and not reset.
- Reset asserted mid-operation clears all state immediately, including FIFO contents and the sticky result.
- Read latency 1 cycle; no wait states; back-to-back accesses every cycle.
- done/pass/fail_code are visible the cycle after the TOHOST write edge.
- char_valid rises the cycle after the push edge into an empty FIFO. There is no same-cycle write-through.
- char_data is stable while char_valid=1 and no pop occurs.
- After a pop, the next byte is presented in the following cycle.

## Test plan
- Reset, then idle 10 cycles, then read CYCLE at offset 0xC -> rdata=10 (±1 per read-issue convention documented in the bench); all other outputs 0.
- Write 1 to BASE+0 -> next cycle done=1, pass=1. Then write 7 to BASE+0 -> unchanged. Read CYCLE twice 5 cycles apart -> equal values.
- Write 32'h0000_0007 to BASE+0 after reset -> done=1, pass=0, fail_code=3.
- char_ready=0, push 0x41..0x48 (8 bytes), then push 0x49 -> STATUS count=8, overflow=1. Raise char_ready -> drains exactly 0x41..0x48 in order, one per cycle, then char_valid=0.
- FIFO full, char_ready=1 during a push of 0x5A -> count stays 8, no overflow, 0x5A emerges last.
- Push 3 bytes, assert rst mid-drain -> char_valid=0 and STATUS=0 immediately. After release, pushes restart with pointers at 0.
